axi_rd_intf: RTL and testbench

//  AXI4 read-side slave interface of the AXI-to-APB bridge; read-direction counterpart of the write interface.

---
 rtl/axi_rd_intf.sv | 265 ++++++++++++++++++++++++++
 tb/tb_axi_rd_intf.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_intf.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_intf
// Purpose  : AXI4 read-side slave interface of the AXI-to-APB bridge. Takes
//            one AR burst at a time, works out the byte address of each beat
//            (FIXED / INCR / WRAP), issues one read request per beat to the
//            APB master side and returns every beat on the R channel with
//            RID / RRESP / RLAST. Illegal bursts are answered with SLVERR
//            beats and never reach the APB side.
// Ports    : ACLK_i, ARESETn_i            clock, async active-low reset
//            AR*_i / ARREADY_o            AXI read address channel
//            R*_o / RREADY_i              AXI read data channel
//            rreq_vld_o/rdy_i/addr_o      per-beat read request to APB side
//            rrsp_vld_i/rdy_o/data_i/err_i per-beat read response from APB
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_intf #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              ACLK_i,
  input  logic              ARESETn_i,
  input  logic [ID_W-1:0]   ARID_i,
  input  logic [ADDR_W-1:0] ARADDR_i,
  input  logic [7:0]        ARLEN_i,
  input  logic [2:0]        ARSIZE_i,
  input  logic [1:0]        ARBURST_i,
  input  logic              ARVALID_i,
  output logic              ARREADY_o,
  output logic [ID_W-1:0]   RID_o,
  output logic [DATA_W-1:0] RDATA_o,
  output logic [1:0]        RRESP_o,
  output logic              RLAST_o,
  output logic              RVALID_o,
  input  logic              RREADY_i,
  output logic              rreq_vld_o,
  input  logic              rreq_rdy_i,
  output logic [ADDR_W-1:0] rreq_addr_o,
  input  logic              rrsp_vld_i,
  output logic              rrsp_rdy_o,
  input  logic [DATA_W-1:0] rrsp_data_i,
  input  logic              rrsp_err_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] BUS_BYTES = 32'(DATA_W / 8);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]        state_q,    state_d;
  logic              arready_q,  arready_d;
  logic [ID_W-1:0]   id_q,       id_d;
  logic [ADDR_W-1:0] start_q,    start_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [7:0]        len_q,      len_d;
  logic [2:0]        size_q,     size_d;
  logic [1:0]        burst_q,    burst_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              rvalid_q,   rvalid_d;
  logic [DATA_W-1:0] rdata_q,    rdata_d;
  logic [1:0]        rresp_q,    rresp_d;
  logic              rlast_q,    rlast_d;

  // --------------------------------------------------------------------------
  // Burst legality, evaluated on the incoming AR fields
  // --------------------------------------------------------------------------
  logic [31:0] w_ar_nb;
  logic        w_ar_wrap_len_ok;
  logic        w_ar_illegal;

  always_comb begin
    w_ar_nb          = 32'd1 << ARSIZE_i;
    w_ar_wrap_len_ok = (ARLEN_i == 8'd1) || (ARLEN_i == 8'd3) ||
                       (ARLEN_i == 8'd7) || (ARLEN_i == 8'd15);
    w_ar_illegal     = (w_ar_nb > BUS_BYTES) ||
                       (ARBURST_i == 2'b11) ||
                       ((ARBURST_i == BURST_WRAP) && !w_ar_wrap_len_ok);
  end

  // --------------------------------------------------------------------------
  // Next-beat address. All arithmetic is modulo 2^ADDR_W, so INCR bursts that
  // run off the top of the register space simply wrap to address 0.
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] w_nb;
  logic [ADDR_W-1:0] w_aligned;
  logic [ADDR_W-1:0] w_incr;
  logic [ADDR_W-1:0] w_wsz;
  logic [ADDR_W-1:0] w_bnd;
  logic [ADDR_W-1:0] w_next_addr;

  always_comb begin
    w_nb      = ADDR_W'(1) << size_q;
    w_aligned = cur_addr_q & ~(w_nb - ADDR_W'(1));
    w_incr    = w_aligned + w_nb;
    // Wrap container size is beat size times beat count; legal WRAP lengths
    // make this a power of two, so masking gives the lower boundary.
    w_wsz     = w_nb * ADDR_W'({1'b0, len_q} + 9'd1);
    w_bnd     = start_q & ~(w_wsz - ADDR_W'(1));
    case (burst_q)
      BURST_FIXED: w_next_addr = cur_addr_q;
      BURST_INCR:  w_next_addr = w_incr;
      BURST_WRAP:  w_next_addr = (w_incr == (w_bnd + w_wsz)) ? w_bnd : w_incr;
      default:     w_next_addr = cur_addr_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    arready_d  = arready_q;
    id_d       = id_q;
    start_d    = start_q;
    cur_addr_d = cur_addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;

    case (state_q)
      S_IDLE: begin
        // Ready is registered: it comes up one clock after reset release or
        // after the final beat of the previous burst is accepted.
        arready_d = 1'b1;
        if (ARVALID_i && arready_q) begin
          arready_d  = 1'b0;
          id_d       = ARID_i;
          start_d    = ARADDR_i;
          cur_addr_d = ARADDR_i;
          len_d      = ARLEN_i;
          size_d     = ARSIZE_i;
          burst_d    = ARBURST_i;
          beat_cnt_d = 8'd0;
          if (w_ar_illegal) begin
            // Error beats need no APB access, so the first one is presented
            // straight away.
            state_d  = S_ERR;
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            rlast_d  = (ARLEN_i == 8'd0);
          end else begin
            state_d  = S_REQ;
          end
        end
      end

      S_REQ: begin
        if (rreq_rdy_i) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (rrsp_vld_i) begin
          rdata_d  = rrsp_data_i;
          rresp_d  = rrsp_err_i ? RESP_SLVERR : RESP_OKAY;
          rvalid_d = 1'b1;
          rlast_d  = (beat_cnt_q == len_q);
          state_d  = S_RESP;
        end
      end

      S_RESP: begin
        // The next request waits for the R handshake, so a stalled master
        // never has more than one beat in flight.
        if (RREADY_i) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            state_d   = S_IDLE;
            arready_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            cur_addr_d = w_next_addr;
            state_d    = S_REQ;
          end
        end
      end

      S_ERR: begin
        if (RREADY_i) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            state_d   = S_IDLE;
            arready_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            rlast_d    = ((beat_cnt_q + 8'd1) == len_q);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      state_q    <= S_IDLE;
      arready_q  <= 1'b0;
      id_q       <= '0;
      start_q    <= '0;
      cur_addr_q <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      arready_q  <= arready_d;
      id_q       <= id_d;
      start_q    <= start_d;
      cur_addr_q <= cur_addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Request/response handshakes decode straight from the state
  // register so they fall the instant reset is asserted.
  // --------------------------------------------------------------------------
  assign ARREADY_o   = arready_q;
  assign RID_o       = id_q;
  assign RDATA_o     = rdata_q;
  assign RRESP_o     = rresp_q;
  assign RLAST_o     = rlast_q;
  assign RVALID_o    = rvalid_q;
  assign rreq_vld_o  = (state_q == S_REQ);
  assign rreq_addr_o = cur_addr_q;
  assign rrsp_rdy_o  = (state_q == S_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_intf.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_intf
// Purpose  : Self-checking bench for axi_rd_intf. A table of bursts with
//            hand-computed beat addresses is replayed against the DUT while
//            the bench plays the AXI master and the APB side; extra sequences
//            cover R back-pressure and reset in the middle of a burst.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_intf;

  logic        ACLK_i;
  logic        ARESETn_i;
  logic [3:0]  ARID_i;
  logic [11:0] ARADDR_i;
  logic [7:0]  ARLEN_i;
  logic [2:0]  ARSIZE_i;
  logic [1:0]  ARBURST_i;
  logic        ARVALID_i;
  logic        ARREADY_o;
  logic [3:0]  RID_o;
  logic [31:0] RDATA_o;
  logic [1:0]  RRESP_o;
  logic        RLAST_o;
  logic        RVALID_o;
  logic        RREADY_i;
  logic        rreq_vld_o;
  logic        rreq_rdy_i;
  logic [11:0] rreq_addr_o;
  logic        rrsp_vld_i;
  logic        rrsp_rdy_o;
  logic [31:0] rrsp_data_i;
  logic        rrsp_err_i;

  axi_rd_intf #(.ID_W(4), .ADDR_W(12), .DATA_W(32)) dut (
    .ACLK_i      (ACLK_i),
    .ARESETn_i   (ARESETn_i),
    .ARID_i      (ARID_i),
    .ARADDR_i    (ARADDR_i),
    .ARLEN_i     (ARLEN_i),
    .ARSIZE_i    (ARSIZE_i),
    .ARBURST_i   (ARBURST_i),
    .ARVALID_i   (ARVALID_i),
    .ARREADY_o   (ARREADY_o),
    .RID_o       (RID_o),
    .RDATA_o     (RDATA_o),
    .RRESP_o     (RRESP_o),
    .RLAST_o     (RLAST_o),
    .RVALID_o    (RVALID_o),
    .RREADY_i    (RREADY_i),
    .rreq_vld_o  (rreq_vld_o),
    .rreq_rdy_i  (rreq_rdy_i),
    .rreq_addr_o (rreq_addr_o),
    .rrsp_vld_i  (rrsp_vld_i),
    .rrsp_rdy_o  (rrsp_rdy_o),
    .rrsp_data_i (rrsp_data_i),
    .rrsp_err_i  (rrsp_err_i)
  );

  initial ACLK_i = 1'b0;
  always #5 ACLK_i = ~ACLK_i;

  typedef struct {
    logic [3:0]        id;
    logic [11:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              illegal;     // expect SLVERR beats and no requests
    int                err_beat;    // beat answered with PSLVERR (-1 none)
    int                stall_beat;  // beat held with RREADY low (-1 none)
    int                stall_cyc;
    int                rdy_dly;     // cycles rreq_rdy_i is held low per beat
    logic [3:0][11:0]  exp_addr;    // expected rreq_addr_o per beat
  } vec_t;

  localparam int NVEC = 12;
  vec_t vt [NVEC];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic [3:0] id, input logic [11:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic illegal,
                              input int err_beat, input int stall_beat,
                              input int stall_cyc, input int rdy_dly,
                              input logic [11:0] a0, input logic [11:0] a1,
                              input logic [11:0] a2, input logic [11:0] a3);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.illegal = illegal; v.err_beat = err_beat; v.stall_beat = stall_beat;
    v.stall_cyc = stall_cyc; v.rdy_dly = rdy_dly;
    v.exp_addr[0] = a0; v.exp_addr[1] = a1;
    v.exp_addr[2] = a2; v.exp_addr[3] = a3;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_ar(input vec_t v);
    int n;
    ARID_i    = v.id;
    ARADDR_i  = v.addr;
    ARLEN_i   = v.len;
    ARSIZE_i  = v.size;
    ARBURST_i = v.burst;
    ARVALID_i = 1'b1;
    n = 0;
    while (!ARREADY_o && n < 20) begin
      @(negedge ACLK_i);
      n++;
    end
    chk("ar_ready_seen", ARREADY_o, 1);
    @(negedge ACLK_i);
    ARVALID_i = 1'b0;
    chk("ar_ready_drop", ARREADY_o, 0);
  endtask

  // Legal burst; abort_beat >= 0 asserts reset while that beat sits in WAIT.
  task automatic run_legal(input int vi, input int abort_beat);
    vec_t        v;
    int          n;
    logic [31:0] dat;
    v = vt[vi];
    do_ar(v);
    chk("rreq_first_cycle", rreq_vld_o, 1);
    for (int b = 0; b <= int'(v.len); b++) begin
      n = 0;
      while (!rreq_vld_o && n < 20) begin
        @(negedge ACLK_i);
        n++;
      end
      chk("rreq_vld", rreq_vld_o, 1);
      chk("rreq_addr", rreq_addr_o, v.exp_addr[b]);
      for (int k = 0; k < v.rdy_dly; k++) begin
        @(negedge ACLK_i);
        chk("rreq_hold_vld", rreq_vld_o, 1);
        chk("rreq_hold_addr", rreq_addr_o, v.exp_addr[b]);
      end
      rreq_rdy_i = 1'b1;
      @(negedge ACLK_i);
      rreq_rdy_i = 1'b0;
      chk("rreq_drop", rreq_vld_o, 0);
      chk("rrsp_rdy", rrsp_rdy_o, 1);
      if (b == abort_beat) begin
        ARESETn_i = 1'b0;
        #1;
        chk("rst_rvalid", RVALID_o, 0);
        chk("rst_rreq_vld", rreq_vld_o, 0);
        chk("rst_rrsp_rdy", rrsp_rdy_o, 0);
        chk("rst_arready", ARREADY_o, 0);
        @(negedge ACLK_i);
        ARESETn_i = 1'b1;
        @(negedge ACLK_i);
        chk("rst_arready_back", ARREADY_o, 1);
        return;
      end
      dat = 32'hD000_0000 | 32'(vi << 8) | 32'(b);
      rrsp_vld_i  = 1'b1;
      rrsp_data_i = dat;
      rrsp_err_i  = (b == v.err_beat);
      @(negedge ACLK_i);
      rrsp_vld_i = 1'b0;
      rrsp_err_i = 1'b0;
      chk("rvalid", RVALID_o, 1);
      chk("rdata", RDATA_o, dat);
      chk("rresp", RRESP_o, (b == v.err_beat) ? 2'b10 : 2'b00);
      chk("rlast", RLAST_o, (b == int'(v.len)));
      chk("rid", RID_o, v.id);
      if (b == v.stall_beat) begin
        for (int k = 0; k < v.stall_cyc; k++) begin
          @(negedge ACLK_i);
          chk("stall_rvalid", RVALID_o, 1);
          chk("stall_rdata", RDATA_o, dat);
          chk("stall_rresp", RRESP_o, (b == v.err_beat) ? 2'b10 : 2'b00);
          chk("stall_no_rreq", rreq_vld_o, 0);
        end
      end
      RREADY_i = 1'b1;
      @(negedge ACLK_i);
      RREADY_i = 1'b0;
      chk("rvalid_drop", RVALID_o, 0);
    end
    chk("arready_back", ARREADY_o, 1);
  endtask

  task automatic run_illegal(input int vi);
    vec_t v;
    int   n;
    int   pulses;
    v = vt[vi];
    pulses = 0;
    do_ar(v);
    for (int b = 0; b <= int'(v.len); b++) begin
      n = 0;
      while (!RVALID_o && n < 20) begin
        if (rreq_vld_o) pulses++;
        @(negedge ACLK_i);
        n++;
      end
      if (rreq_vld_o) pulses++;
      chk("err_rvalid", RVALID_o, 1);
      chk("err_rdata", RDATA_o, 0);
      chk("err_rresp", RRESP_o, 2'b10);
      chk("err_rlast", RLAST_o, (b == int'(v.len)));
      chk("err_rid", RID_o, v.id);
      RREADY_i = 1'b1;
      @(negedge ACLK_i);
      RREADY_i = 1'b0;
    end
    if (rreq_vld_o) pulses++;
    chk("err_rvalid_drop", RVALID_o, 0);
    chk("err_arready_back", ARREADY_o, 1);
    chk("err_rreq_pulses", pulses, 0);
  endtask

  initial begin
    //            id     addr     len   sz    burst  ill  err st  sc rd  beat addresses
    vt[0]  = mk(4'h5, 12'h010, 8'd3, 3'd2, 2'b01, 1'b0, -1, -1, 0, 0, 12'h010, 12'h014, 12'h018, 12'h01C);
    vt[1]  = mk(4'h9, 12'h018, 8'd3, 3'd2, 2'b10, 1'b0, -1, -1, 0, 2, 12'h018, 12'h01C, 12'h010, 12'h014);
    vt[2]  = mk(4'h3, 12'h020, 8'd1, 3'd2, 2'b00, 1'b0, -1, -1, 0, 0, 12'h020, 12'h020, 12'h000, 12'h000);
    vt[3]  = mk(4'h6, 12'h100, 8'd1, 3'd2, 2'b01, 1'b0, -1,  0, 5, 0, 12'h100, 12'h104, 12'h000, 12'h000);
    vt[4]  = mk(4'h2, 12'h040, 8'd2, 3'd2, 2'b01, 1'b0,  1, -1, 0, 1, 12'h040, 12'h044, 12'h048, 12'h000);
    vt[5]  = mk(4'h7, 12'hFF8, 8'd3, 3'd2, 2'b01, 1'b0, -1, -1, 0, 0, 12'hFF8, 12'hFFC, 12'h000, 12'h004);
    vt[6]  = mk(4'h4, 12'h013, 8'd2, 3'd2, 2'b01, 1'b0, -1, -1, 0, 0, 12'h013, 12'h014, 12'h018, 12'h000);
    vt[7]  = mk(4'hB, 12'h01C, 8'd1, 3'd2, 2'b10, 1'b0, -1, -1, 0, 0, 12'h01C, 12'h018, 12'h000, 12'h000);
    vt[8]  = mk(4'hC, 12'h0FE, 8'd1, 3'd1, 2'b10, 1'b0, -1, -1, 0, 0, 12'h0FE, 12'h0FC, 12'h000, 12'h000);
    vt[9]  = mk(4'h8, 12'h030, 8'd2, 3'd3, 2'b01, 1'b1, -1, -1, 0, 0, 12'h000, 12'h000, 12'h000, 12'h000);
    vt[10] = mk(4'hA, 12'h030, 8'd0, 3'd2, 2'b11, 1'b1, -1, -1, 0, 0, 12'h000, 12'h000, 12'h000, 12'h000);
    vt[11] = mk(4'hD, 12'h030, 8'd2, 3'd2, 2'b10, 1'b1, -1, -1, 0, 0, 12'h000, 12'h000, 12'h000, 12'h000);

    ARESETn_i   = 1'b0;
    ARID_i      = '0;
    ARADDR_i    = '0;
    ARLEN_i     = '0;
    ARSIZE_i    = '0;
    ARBURST_i   = '0;
    ARVALID_i   = 1'b0;
    RREADY_i    = 1'b0;
    rreq_rdy_i  = 1'b0;
    rrsp_vld_i  = 1'b0;
    rrsp_data_i = '0;
    rrsp_err_i  = 1'b0;

    repeat (3) @(negedge ACLK_i);
    chk("reset_arready", ARREADY_o, 0);
    chk("reset_rvalid", RVALID_o, 0);
    chk("reset_rreq_vld", rreq_vld_o, 0);
    chk("reset_rrsp_rdy", rrsp_rdy_o, 0);
    chk("reset_rdata", RDATA_o, 0);
    chk("reset_rlast", RLAST_o, 0);
    ARESETn_i = 1'b1;
    #1;
    chk("release_arready_low", ARREADY_o, 0);
    @(negedge ACLK_i);
    chk("release_arready_high", ARREADY_o, 1);

    for (int i = 0; i < NVEC; i++) begin
      if (vt[i].illegal) run_illegal(i);
      else               run_legal(i, -1);
    end

    // Reset while beat 2 of an INCR burst waits for its APB response, then a
    // fresh burst must run normally.
    run_legal(0, 2);
    run_legal(5, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
